tone_synth_i2s: RTL and testbench
=================================

TONE_SYNTH_I2S -- requirements
Module: tone_synth_i2s

Interface
REQ-001 SHALL have parameter REF_CLK, default 18432000, master clock frequency in Hz.
REQ-002 SHALL have parameter SAMPLE_RATE, default 48000, frame rate in Hz.
REQ-003 SHALL have parameter DATA_WIDTH, default 16, bits per slot.
REQ-004 SHALL have parameter CH_NUM, default 4, voice count (power of 2, 1..16).
REQ-005 SHALL have parameter ACC_WIDTH, default 16, phase accumulator width.
REQ-006 SHALL have port iCLK_18_4  in  1  master clock; all logic on its rising edge (only clock in the design).
REQ-007 SHALL have port iRST_N  in  1  asynchronous active-low reset.
REQ-008 SHALL have port ch_en  in  CH_NUM  per-voice enable.
REQ-009 SHALL have port ch_f  in  CH_NUM*ACC_WIDTH  per-voice phase increment; voice i is bits [i*ACC_WIDTH +: ACC_WIDTH].
REQ-010 SHALL have port ch_wave  in  CH_NUM*2  per-voice waveform: 0 square, 1 saw, 2 triangle, 3 silent.
REQ-011 SHALL have port oAUD_BCK  out  1  bit clock, registered.
REQ-012 SHALL have port oAUD_LRCK  out  1  word clock; low = left slot, high = right slot.
REQ-013 SHALL have port oAUD_DATA  out  1  serial data, MSB first.
REQ-014 SHALL have port sample_strobe  out  1  one-cycle pulse when a new mixed sample is loaded.

Function
REQ-015 SHALL toggle oAUD_BCK every HALF = REF_CLK/(SAMPLE_RATE*DATA_WIDTH*4) clocks (default 6); BCK rise/fall are internal enables, not clocks.
REQ-016 SHALL count bits 0..2*DATA_WIDTH-1 on each BCK falling event; oAUD_LRCK = count >= DATA_WIDTH; frame = 2*DATA_WIDTH BCK periods (default 384 clocks).
REQ-017 SHALL use left-justified format: MSB driven on the BCK falling event that changes LRCK, no one-bit delay; data changes only on falling events.
REQ-018 SHALL transmit the same mixed sample in both slots (mono duplicated).
REQ-019 SHALL, at the frame tick (falling event where count wraps to 0), load the mixed sample into the shift register, pulse sample_strobe, then add ch_f to each enabled voice phase.
REQ-020 SHALL sample ch_en, ch_f, ch_wave only at the frame tick; mid-frame changes never alter the word in flight.
REQ-021 SHALL wrap phase modulo 2^ACC_WIDTH; no clamp or early reset.
REQ-022 SHALL produce per voice a signed value of VW = DATA_WIDTH - log2(CH_NUM) bits, from the phase top VW bits: square +max when phase MSB 0, -max-1 when 1; saw = top bits with MSB inverted; triangle = folded saw doubled; silent = 0.
REQ-023 SHALL mix by signed sign-extended sum into DATA_WIDTH bits; overflow is impossible by construction.
REQ-024 SHALL, for a voice sampled disabled, contribute 0 and clear its phase to 0; first enabled frame uses phase 0.
REQ-025 SHALL, with ch_f = 0 on an enabled voice, hold phase constant (DC output).

Reset
REQ-026 SHALL, on iRST_N low, asynchronously clear dividers, bit count, phases, shift register; oAUD_BCK, oAUD_LRCK, oAUD_DATA, sample_strobe = 0.
REQ-027 SHALL, after reset release, toggle BCK first after HALF clocks and begin a left slot; reset mid-frame abandons the word.
REQ-028 SHALL transmit zero in the first frame after reset; first frame tick occurs at the wrap ending that frame.

Configuration
REQ-029 SHALL, with TONE_SYNTH_VOLUME_EN defined, add port ch_vol  in  CH_NUM*4, sampled at frame tick; voice value = (value * vol) >>> 4, arithmetic.
REQ-030 SHALL, without TONE_SYNTH_VOLUME_EN, omit ch_vol; voices at full amplitude.

Structure
REQ-031 SHALL place the waveform encoding enum, the default parameter constants, and the HALF/frame-length calculations in package tone_synth_pkg.
REQ-032 SHALL implement one voice (phase register, waveform decode, optional volume) as sub-module tone_voice, instantiated CH_NUM times.

Verification
REQ-033 Reset then release -> oAUD_BCK rises at clock 6; LRCK low for 16 BCK, high 16; first frame data all 0.
REQ-034 Voice0 square, f=0x0400, others off -> words 0x1FFF for 32 frames, then 0xE000 for 32, period 64 frames.
REQ-035 All four square, f=0 -> every slot carries 0x7FFC (4*8191), L and R identical.
REQ-036 Voice0 square, f=0x8000 -> alternates 0x1FFF/0xE000 each frame; f=0xFFFF wraps with no clamp.
REQ-037 Disable voice0 mid-frame -> current word completes unchanged; next word 0; re-enable restarts at 0x1FFF.
REQ-038 TONE_SYNTH_VOLUME_EN, square f=0, vol=8 -> word 0x0FFF; vol=0 -> 0x0000.

Source files
------------

// File: rtl/tone_synth_pkg.sv
// Shared definitions for the tone synthesizer: waveform encoding, default
// parameter values and the I2S clock-divider arithmetic.
package tone_synth_pkg;

  typedef enum logic [1:0] {
    WAVE_SQUARE = 2'd0,
    WAVE_SAW    = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SILENT = 2'd3
  } wave_t;

  localparam int DEF_REF_CLK     = 18432000;
  localparam int DEF_SAMPLE_RATE = 48000;
  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_CH_NUM      = 4;
  localparam int DEF_ACC_WIDTH   = 16;

  // Master clocks per BCK half period.
  function automatic int calc_half(input int ref_clk, input int sample_rate, input int data_width);
    return ref_clk / (sample_rate * data_width * 4);
  endfunction

  // Master clocks per frame: two slots of data_width BCK periods each.
  function automatic int calc_frame_clks(input int half, input int data_width);
    return 2 * half * 2 * data_width;
  endfunction

  // Per-voice width that leaves headroom so the mix can never overflow.
  function automatic int calc_voice_width(input int data_width, input int ch_num);
    return data_width - $clog2(ch_num);
  endfunction

endpackage

// File: rtl/tone_synth_i2s_voice.sv
// One synthesizer voice: phase accumulator plus waveform decode.
// Optional per-voice volume is enabled with TONE_SYNTH_VOLUME_EN.
module tone_voice
  import tone_synth_pkg::*;
#(
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int VW        = DEF_DATA_WIDTH - 2
) (
  input  logic                 iCLK_18_4,
  input  logic                 iRST_N,
  input  logic                 frame_tick,
  input  logic                 en,
  input  logic [ACC_WIDTH-1:0] f,
  input  logic [1:0]           wave,
`ifdef TONE_SYNTH_VOLUME_EN
  input  logic [3:0]           vol,
`endif
  output logic signed [VW-1:0] value
);

  logic [ACC_WIDTH-1:0] phase_q;
  logic [VW-1:0]        top;
  logic [VW-2:0]        fold;
  logic [VW-1:0]        dbl;
  logic signed [VW-1:0] raw;

  // Advance the phase once per frame; a disabled voice restarts from zero.
  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      phase_q <= '0;
    end else if (frame_tick) begin
      phase_q <= en ? phase_q + f : '0;
    end
  end

  if (ACC_WIDTH >= VW) begin : g_top
    assign top = phase_q[ACC_WIDTH-1 -: VW];
  end else begin : g_top_pad
    assign top = {phase_q, {(VW-ACC_WIDTH){1'b0}}};
  end

  // Decode the waveform from the top phase bits into a signed sample.
  always_comb begin
    fold = top[VW-1] ? ~top[VW-2:0] : top[VW-2:0];
    dbl  = {fold, 1'b0};
    raw  = '0;
    case (wave_t'(wave))
      WAVE_SQUARE: raw = top[VW-1] ? {1'b1, {(VW-1){1'b0}}} : {1'b0, {(VW-1){1'b1}}};
      WAVE_SAW:    raw = {~top[VW-1], top[VW-2:0]};
      WAVE_TRI:    raw = {~dbl[VW-1], dbl[VW-2:0]};
      default:     raw = '0;
    endcase
  end

`ifdef TONE_SYNTH_VOLUME_EN
  logic signed [VW+3:0] prod;

  // Scale by vol/16 with an arithmetic shift so negative samples stay negative.
  always_comb begin
    prod  = (VW+4)'(raw) * (VW+4)'($signed({1'b0, vol}));
    value = en ? VW'(prod >>> 4) : '0;
  end
`else
  // Full-amplitude output; a disabled voice contributes nothing.
  always_comb begin
    value = en ? raw : '0;
  end
`endif

endmodule

// File: rtl/tone_synth_i2s.sv
// Multi-voice tone synthesizer with a left-justified I2S master transmitter.
// The mono mix is duplicated into both slots. Defining TONE_SYNTH_VOLUME_EN
// adds the per-voice ch_vol port.
module tone_synth_i2s
  import tone_synth_pkg::*;
#(
  parameter int REF_CLK     = DEF_REF_CLK,
  parameter int SAMPLE_RATE = DEF_SAMPLE_RATE,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int CH_NUM      = DEF_CH_NUM,
  parameter int ACC_WIDTH   = DEF_ACC_WIDTH
) (
  input  logic                          iCLK_18_4,
  input  logic                          iRST_N,
  input  logic [CH_NUM-1:0]             ch_en,
  input  logic [CH_NUM*ACC_WIDTH-1:0]   ch_f,
  input  logic [CH_NUM*2-1:0]           ch_wave,
`ifdef TONE_SYNTH_VOLUME_EN
  input  logic [CH_NUM*4-1:0]           ch_vol,
`endif
  output logic                          oAUD_BCK,
  output logic                          oAUD_LRCK,
  output logic                          oAUD_DATA,
  output logic                          sample_strobe
);

  localparam int HALF = calc_half(REF_CLK, SAMPLE_RATE, DATA_WIDTH);
  localparam int VW   = calc_voice_width(DATA_WIDTH, CH_NUM);
  localparam int HCW  = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int BCW  = $clog2(2 * DATA_WIDTH);

  logic [HCW-1:0]         half_cnt;
  logic [BCW-1:0]         bit_cnt;
  logic [BCW-1:0]         next_bit_cnt;
  logic [DATA_WIDTH-1:0]  shift_q;
  logic [DATA_WIDTH-1:0]  sample_q;
  logic                   half_done;
  logic                   fall_evt;
  logic                   frame_tick;
  logic signed [DATA_WIDTH-1:0] mix;
  logic signed [VW-1:0]   voice_val [CH_NUM];

  assign half_done  = (half_cnt == HCW'(HALF - 1));
  assign fall_evt   = half_done && oAUD_BCK;
  assign frame_tick = fall_evt && (bit_cnt == BCW'(2 * DATA_WIDTH - 1));
  assign oAUD_DATA  = shift_q[DATA_WIDTH-1];

  for (genvar i = 0; i < CH_NUM; i++) begin : g_voice
    tone_voice #(
      .ACC_WIDTH(ACC_WIDTH),
      .VW       (VW)
    ) u_voice (
      .iCLK_18_4 (iCLK_18_4),
      .iRST_N    (iRST_N),
      .frame_tick(frame_tick),
      .en        (ch_en[i]),
      .f         (ch_f[i*ACC_WIDTH +: ACC_WIDTH]),
      .wave      (ch_wave[i*2 +: 2]),
`ifdef TONE_SYNTH_VOLUME_EN
      .vol       (ch_vol[i*4 +: 4]),
`endif
      .value     (voice_val[i])
    );
  end

  // Sign-extended sum of all voices; voice width leaves room for CH_NUM terms.
  always_comb begin
    mix = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      mix = mix + DATA_WIDTH'(voice_val[i]);
    end
  end

  // Bit counter wraps explicitly so non-power-of-two frames also work.
  always_comb begin
    next_bit_cnt = (bit_cnt == BCW'(2 * DATA_WIDTH - 1)) ? '0 : bit_cnt + 1'b1;
  end

  // Bit clock divider: toggle BCK every HALF master clocks.
  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      half_cnt <= '0;
      oAUD_BCK <= 1'b0;
    end else if (half_done) begin
      half_cnt <= '0;
      oAUD_BCK <= ~oAUD_BCK;
    end else begin
      half_cnt <= half_cnt + 1'b1;
    end
  end

  // On each BCK falling event: advance slot position, update LRCK and shift data.
  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      bit_cnt       <= '0;
      oAUD_LRCK     <= 1'b0;
      shift_q       <= '0;
      sample_q      <= '0;
      sample_strobe <= 1'b0;
    end else begin
      sample_strobe <= frame_tick;
      if (fall_evt) begin
        bit_cnt   <= next_bit_cnt;
        oAUD_LRCK <= (next_bit_cnt >= BCW'(DATA_WIDTH));
        if (frame_tick) begin
          shift_q  <= mix;
          sample_q <= mix;
        end else if (next_bit_cnt == BCW'(DATA_WIDTH)) begin
          shift_q <= sample_q;
        end else begin
          shift_q <= {shift_q[DATA_WIDTH-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_tone_synth_i2s.sv
// Self-checking bench for tone_synth_i2s (default build, full amplitude).
module tb_tone_synth_i2s;

  localparam int DW    = 16;
  localparam int CH    = 4;
  localparam int ACC   = 16;
  localparam int VW    = 14;
  localparam int FRAME = 384;
  localparam int HVW   = 1 << (VW - 1);
  localparam int FVW   = 1 << VW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [CH-1:0]   ch_en;
  logic [CH*ACC-1:0] ch_f;
  logic [CH*2-1:0] ch_wave;
  logic            aud_bck, aud_lrck, aud_data, strobe;

  int checks = 0;
  int failures = 0;
  int n = 0;
  int words[$];
  int phase[CH];
  int rx_log[$];
  logic [DW-1:0] rx_shift = '0;
  int rx_bits = 0;
  logic prev_bck = 1'b0;

  always #5 clk = ~clk;

  tone_synth_i2s dut (
    .iCLK_18_4    (clk),
    .iRST_N       (rst_n),
    .ch_en        (ch_en),
    .ch_f         (ch_f),
    .ch_wave      (ch_wave),
    .oAUD_BCK     (aud_bck),
    .oAUD_LRCK    (aud_lrck),
    .oAUD_DATA    (aud_data),
    .sample_strobe(strobe)
  );

  // Voice value straight from the waveform definitions, in plain integers.
  function automatic int voice_value(input logic [1:0] wave, input int ph);
    int top;
    int fold;
    top = ph >> (ACC - VW);
    case (wave)
      2'd0: return (ph >= (1 << (ACC - 1))) ? -HVW : HVW - 1;
      2'd1: return top - HVW;
      2'd2: begin
        fold = (top < HVW) ? top : FVW - 1 - top;
        return 2 * fold - HVW;
      end
      default: return 0;
    endcase
  endfunction

  // Model: count clocks since reset, build the word of every frame at its tick.
  always @(posedge clk) begin
    if (!rst_n) begin
      n = 0;
      words.delete();
      words.push_back(0);
      for (int v = 0; v < CH; v++) phase[v] = 0;
    end else begin
      n = n + 1;
      if (n % FRAME == 0) begin
        int w;
        w = 0;
        for (int v = 0; v < CH; v++) begin
          if (ch_en[v]) begin
            w = w + voice_value(ch_wave[2*v +: 2], phase[v]);
            phase[v] = (phase[v] + int'(ch_f[v*ACC +: ACC])) % 65536;
          end else begin
            phase[v] = 0;
          end
        end
        words.push_back(w & 32'h0000FFFF);
      end
    end
  end

  // Per-cycle compare of all four outputs against the model.
  always @(negedge clk) begin
    logic [3:0] exp_v;
    logic [3:0] act_v;
    int b;
    int fr;
    int wd;
    act_v = {aud_bck, aud_lrck, aud_data, strobe};
    exp_v = 4'b0000;
    if (rst_n) begin
      b  = (n / 12) % 32;
      fr = n / FRAME;
      wd = (fr < words.size()) ? words[fr] : 0;
      exp_v[3] = ((n / 6) % 2) == 1;
      exp_v[2] = (b >= DW);
      exp_v[1] = wd[DW - 1 - (b % DW)];
      exp_v[0] = (n % FRAME == 0) && (n != 0);
    end
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("[TB] FAIL cycle n=%0d bck/lrck/data/strobe got=%b want=%b", n, act_v, exp_v);
    end
  end

  // Deserializer: capture DATA on BCK rising, 16 bits per slot.
  always @(negedge clk) begin
    if (!rst_n) begin
      rx_bits = 0;
      rx_log.delete();
      prev_bck = 1'b0;
    end else begin
      if (aud_bck && !prev_bck) begin
        rx_shift = {rx_shift[DW-2:0], aud_data};
        rx_bits++;
        if (rx_bits == DW) begin
          rx_log.push_back(int'(rx_shift));
          rx_bits = 0;
        end
      end
      prev_bck = aud_bck;
    end
  end

  task automatic wait_phase(input int pos);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while ((n % FRAME) != pos && guard < 2 * FRAME);
    if (guard >= 2 * FRAME) begin
      checks++;
      failures++;
      $display("[TB] FAIL wait_phase timeout got n=%0d want pos=%0d", n, pos);
    end
  endtask

  task automatic applyStimulus(input logic [CH-1:0] en, input logic [CH*2-1:0] wave,
                               input logic [CH*ACC-1:0] f);
    ch_en   = en;
    ch_wave = wave;
    ch_f    = f;
  endtask

  // Compare the left/right words of the frame just completed.
  task automatic checkOutput(input string name, input int exp_l, input int exp_r);
    int l;
    int r;
    checks++;
    if (rx_log.size() < 2) begin
      failures++;
      $display("[TB] FAIL %s got %0d words want >=2", name, rx_log.size());
    end else begin
      l = rx_log[rx_log.size() - 2];
      r = rx_log[rx_log.size() - 1];
      if (l != exp_l || r != exp_r) begin
        failures++;
        $display("[TB] FAIL %s got L=%04h R=%04h want L=%04h R=%04h", name, l, r, exp_l, exp_r);
      end
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("[TB] FAIL %s got=%b want=%b", name, act, want);
    end
  endtask

  task automatic checkReset(input string name);
    checks++;
    if ({aud_bck, aud_lrck, aud_data, strobe} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL %s got=%b want=0000", name, {aud_bck, aud_lrck, aud_data, strobe});
    end
  endtask

  initial begin
    int e;
    applyStimulus('0, '0, '0);
    #1 rst_n = 1'b0;
    repeat (4) @(negedge clk);
    checkReset("reset_state");
    @(negedge clk);
    #1 rst_n = 1'b1;

    repeat (5) @(negedge clk);
    checkBit("bck_low_clk5", aud_bck, 1'b0);
    @(negedge clk);
    checkBit("bck_high_clk6", aud_bck, 1'b1);

    $display("[TB] first frame after reset");
    wait_phase(380);
    checkOutput("first_frame_zero", 0, 0);

    $display("[TB] voice0 square f=0x0400");
    applyStimulus(4'b0001, 8'h00, 64'h0400);
    for (int k = 1; k <= 65; k++) begin
      wait_phase(380);
      e = (((k - 1) / 32) % 2 == 1) ? 16'hE000 : 16'h1FFF;
      checkOutput($sformatf("square_f400_frame%0d", k), e, e);
    end

    $display("[TB] voice0 square f=0x8000");
    applyStimulus(4'b0001, 8'h00, 64'h8000);
    for (int k = 66; k <= 69; k++) begin
      wait_phase(380);
      e = (k % 2 == 0) ? 16'h1FFF : 16'hE000;
      checkOutput($sformatf("square_f8000_frame%0d", k), e, e);
    end

    applyStimulus(4'b0000, 8'h00, 64'h8000);
    wait_phase(380);
    checkOutput("disable_gives_zero", 0, 0);

    $display("[TB] voice0 square f=0xFFFF wrap");
    applyStimulus(4'b0001, 8'h00, 64'hFFFF);
    wait_phase(380);
    checkOutput("ffff_phase0", 16'h1FFF, 16'h1FFF);
    wait_phase(380);
    checkOutput("ffff_wrapped", 16'hE000, 16'hE000);
    wait_phase(380);
    checkOutput("ffff_no_clamp", 16'hE000, 16'hE000);

    $display("[TB] mid-frame disable");
    wait_phase(192);
    applyStimulus(4'b0000, 8'h00, 64'hFFFF);
    wait_phase(380);
    checkOutput("midframe_word_intact", 16'hE000, 16'hE000);
    wait_phase(380);
    checkOutput("disabled_next_zero", 0, 0);
    applyStimulus(4'b0001, 8'h00, 64'hFFFF);
    wait_phase(380);
    checkOutput("reenable_restart", 16'h1FFF, 16'h1FFF);

    $display("[TB] four squares DC");
    applyStimulus(4'b0000, 8'h00, 64'h0);
    wait_phase(380);
    checkOutput("all_off", 0, 0);
    applyStimulus(4'b1111, 8'h00, 64'h0);
    wait_phase(380);
    checkOutput("four_square_dc_a", 16'h7FFC, 16'h7FFC);
    wait_phase(380);
    checkOutput("four_square_dc_b", 16'h7FFC, 16'h7FFC);

    $display("[TB] saw + triangle + silent");
    applyStimulus(4'b0110, 8'h27, {16'h0000, 16'h2000, 16'h1000, 16'h0000});
    wait_phase(380);
    checkOutput("saw_tri_frame0", 16'hC000, 16'hC000);
    wait_phase(380);
    checkOutput("saw_tri_frame1", 16'hD400, 16'hD400);
    wait_phase(380);
    checkOutput("saw_tri_frame2", 16'hE800, 16'hE800);

    $display("[TB] reset mid-frame");
    wait_phase(192);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkReset("midframe_reset_state");
    @(negedge clk);
    #1 rst_n = 1'b1;
    wait_phase(380);
    checkOutput("post_reset_zero", 0, 0);
    wait_phase(380);
    checkOutput("post_reset_phase0", 16'hC000, 16'hC000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
